// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register of the 16-bit pipeline. Captures decoded operands
//   and control from ID, replaces them with a bubble on reset, branch flush
//   or load-use stall, and resolves EX/MEM and MEM/WB forwarding so the ALU
//   operands leave this block ready to use. Stall bubbles are counted in a
//   saturating 16-bit performance counter.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   id_*                          decoded instruction fields from ID
//   flush                         taken branch: kill the instruction entering EX
//   exmem_reg_write/rd/result     EX/MEM forwarding source
//   memwb_reg_write/rd/data       MEM/WB forwarding source
//   alu_input_a/b, alu_control    ALU operands and opcode
//   ex_store_data                 forwarded rt value for stores
//   ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write   EX control
//   stall                         combinational hold request to PC and IF/ID
//   bubble_count                  saturating count of stall bubbles
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [2:0]        id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_input_a,
    output logic [DATA_W-1:0] alu_input_b,
    output logic [2:0]        alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              stall,
    output logic [15:0]       bubble_count
);

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_alu_src;
    logic [2:0]        r_alu_control;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [15:0]       r_bubble_count;

    logic              w_stall;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. A flush kills the ID instruction anyway, so no hold is needed.
    assign w_stall = r_valid & r_mem_read & (r_rd != '0) & id_valid &
                     ((id_rs == r_rd) | (id_rt == r_rd)) & ~flush;

    assign w_bubble = rst | flush | w_stall;

    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_alu_src     <= 1'b0;
            r_alu_control <= 3'b000;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
        end else begin
            r_valid       <= id_valid;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
            r_mem_write   <= id_mem_write;
            r_alu_src     <= id_alu_src;
            r_alu_control <= id_alu_control;
            r_rs          <= id_rs;
            r_rt          <= id_rt;
            r_rd          <= id_rd;
            r_rs_data     <= id_rs_data;
            r_rt_data     <= id_rt_data;
            r_imm         <= id_imm;
        end
    end

    // Only stall bubbles are counted; flush bubbles are excluded because
    // w_stall is already masked by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_count <= 16'd0;
        end else if (w_stall && (r_bubble_count != 16'hFFFF)) begin
            r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    // R0 is never forwarded.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (exmem_reg_write && (exmem_rd == r_rs) && (r_rs != '0)) begin
            w_fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == r_rs) && (r_rs != '0)) begin
            w_fwd_rs = memwb_data;
        end
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (exmem_reg_write && (exmem_rd == r_rt) && (r_rt != '0)) begin
            w_fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == r_rt) && (r_rt != '0)) begin
            w_fwd_rt = memwb_data;
        end
    end

    assign alu_input_a   = w_fwd_rs;
    assign alu_input_b   = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign alu_control   = r_alu_control;
    assign ex_rd         = r_rd;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign stall         = w_stall;
    assign bubble_count  = r_bubble_count;

endmodule
